// File: rtl/uart_pkg.sv
// Shared definitions for the 4-bit odd-parity UART receive path:
// nibble/byte widths, frame-FSM state encoding and a parity helper.
package uart_pkg;

    localparam int NIBBLE_W = 4;
    localparam int BYTE_W   = 8;

    // Frame FSM states. The _E/_O suffix records whether an even or odd
    // number of ones has been seen so far in the frame (data plus parity).
    typedef enum logic [3:0] {
        ST_BREAK    = 4'd0,
        ST_IDLE     = 4'd1,
        ST_START    = 4'd2,
        ST_BIT1_E   = 4'd3,
        ST_BIT1_O   = 4'd4,
        ST_BIT2_E   = 4'd5,
        ST_BIT2_O   = 4'd6,
        ST_BIT3_E   = 4'd7,
        ST_BIT3_O   = 4'd8,
        ST_BIT4_E   = 4'd9,
        ST_BIT4_O   = 4'd10,
        ST_PAR_E    = 4'd11,
        ST_PAR_O    = 4'd12,
        ST_STOP_OK  = 4'd13,
        ST_STOP_ERR = 4'd14
    } frame_state_e;

    // Parity bit that makes the total count of ones over nibble+parity odd.
    function automatic logic odd_parity(input logic [NIBBLE_W-1:0] nib);
        return ~^nib;
    endfunction

endpackage

// File: rtl/uart_rx_frame_fsm.sv
// Per-bit frame tracker for the 4-bit odd-parity UART frame
// (start 0, d0..d3 LSB first, parity, stop 1; one bit per clock).
// All outputs are registered decodes of the next state.
module uart_rx_frame_fsm
    import uart_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic signal,
    output logic frame_ok,
    output logic frame_err,
    output logic frame_brk,
    output logic bit_strobe,
    output logic busy
);

    frame_state_e state_r;
    frame_state_e state_nxt_s;
    logic         busy_nxt_s;
    logic         strobe_nxt_s;
    logic         frame_ok_r;
    logic         frame_err_r;
    logic         frame_brk_r;
    logic         bit_strobe_r;
    logic         busy_r;

    // Next-state logic: parity is folded into the state as bits arrive.
    always_comb begin
        state_nxt_s = state_r;
        if (clear) begin
            state_nxt_s = ST_BREAK;
        end else begin
            case (state_r)
                ST_BREAK:    state_nxt_s = signal ? ST_IDLE   : ST_BREAK;
                ST_IDLE:     state_nxt_s = signal ? ST_IDLE   : ST_START;
                ST_START:    state_nxt_s = signal ? ST_BIT1_O : ST_BIT1_E;
                ST_BIT1_E:   state_nxt_s = signal ? ST_BIT2_O : ST_BIT2_E;
                ST_BIT1_O:   state_nxt_s = signal ? ST_BIT2_E : ST_BIT2_O;
                ST_BIT2_E:   state_nxt_s = signal ? ST_BIT3_O : ST_BIT3_E;
                ST_BIT2_O:   state_nxt_s = signal ? ST_BIT3_E : ST_BIT3_O;
                ST_BIT3_E:   state_nxt_s = signal ? ST_BIT4_O : ST_BIT4_E;
                ST_BIT3_O:   state_nxt_s = signal ? ST_BIT4_E : ST_BIT4_O;
                ST_BIT4_E:   state_nxt_s = signal ? ST_PAR_O  : ST_PAR_E;
                ST_BIT4_O:   state_nxt_s = signal ? ST_PAR_E  : ST_PAR_O;
                ST_PAR_E:    state_nxt_s = signal ? ST_STOP_ERR : ST_BREAK;
                ST_PAR_O:    state_nxt_s = signal ? ST_STOP_OK  : ST_BREAK;
                ST_STOP_OK:  state_nxt_s = signal ? ST_IDLE   : ST_START;
                ST_STOP_ERR: state_nxt_s = signal ? ST_IDLE   : ST_START;
                default:     state_nxt_s = ST_BREAK;
            endcase
        end
    end

    // Output decode of the next state so the registered flags line up with it.
    always_comb begin
        busy_nxt_s   = 1'b0;
        strobe_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_START, ST_BIT1_E, ST_BIT1_O, ST_BIT2_E, ST_BIT2_O,
            ST_BIT3_E, ST_BIT3_O: begin
                busy_nxt_s   = 1'b1;
                strobe_nxt_s = 1'b1;
            end
            ST_BIT4_E, ST_BIT4_O, ST_PAR_E, ST_PAR_O: begin
                busy_nxt_s   = 1'b1;
                strobe_nxt_s = 1'b0;
            end
            default: begin
                busy_nxt_s   = 1'b0;
                strobe_nxt_s = 1'b0;
            end
        endcase
    end

    // State register and registered frame status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_BREAK;
            frame_ok_r   <= 1'b0;
            frame_err_r  <= 1'b0;
            frame_brk_r  <= 1'b0;
            bit_strobe_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            frame_ok_r   <= (state_nxt_s == ST_STOP_OK);
            frame_err_r  <= (state_nxt_s == ST_STOP_ERR);
            frame_brk_r  <= !clear && !signal &&
                            ((state_r == ST_PAR_E) || (state_r == ST_PAR_O));
            bit_strobe_r <= strobe_nxt_s;
            busy_r       <= busy_nxt_s;
        end
    end

    assign frame_ok   = frame_ok_r;
    assign frame_err  = frame_err_r;
    assign frame_brk  = frame_brk_r;
    assign bit_strobe = bit_strobe_r;
    assign busy       = busy_r;

endmodule

// File: rtl/uart_rx_byte_ctrl.sv
// Receive-side controller: captures nibbles from the frame FSM, pairs
// them into bytes, buffers them in a small FIFO with valid/ready output
// and keeps saturating error/break/drop statistics.
// Optional build macro UART_RX_NIBBLE_TIMEOUT_EN flushes a lone low nibble
// as {4'h0, low} after TIMEOUT idle cycles.
module uart_rx_byte_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8,
    parameter int TIMEOUT    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              signal,
    input  logic              enable,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  brk_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              overflow,
    output logic              pending,
    output logic              busy
);

    localparam int             AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Saturating increment for the statistics counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic                frame_ok_s, frame_err_s, frame_brk_s, bit_strobe_s, busy_s;
    logic [NIBBLE_W-1:0] shreg_r;
    logic [1:0]          bit_cnt_r;
    logic [NIBBLE_W-1:0] low_r;
    logic                pending_r;
    logic [BYTE_W-1:0]   mem_r [FIFO_DEPTH];
    logic [AW:0]         wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]    err_r, brk_r, drop_r;
    logic                ovf_r;
    logic                fifo_empty_s, fifo_full_s, pop_s, push_s, drop_s;
    logic                wr_req_s;
    logic [BYTE_W-1:0]   wr_byte_s;
    logic                timeout_hit_s;

    uart_rx_frame_fsm u_frame_fsm (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (!enable),
        .signal     (signal),
        .frame_ok   (frame_ok_s),
        .frame_err  (frame_err_s),
        .frame_brk  (frame_brk_s),
        .bit_strobe (bit_strobe_s),
        .busy       (busy_s)
    );

`ifdef UART_RX_NIBBLE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_cnt_r;
    logic          idle_s;

    // Pending with no frame activity: the FSM is sitting in IDLE.
    assign idle_s        = pending_r && !busy_s && !frame_ok_s && !frame_err_s && !frame_brk_s;
    assign timeout_hit_s = enable && idle_s && (idle_cnt_r == TW'(TIMEOUT - 1));

    // Idle counter; any start bit (busy) or loss of pending restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt_r <= {TW{1'b0}};
        end else if (!enable || !idle_s || timeout_hit_s) begin
            idle_cnt_r <= {TW{1'b0}};
        end else begin
            idle_cnt_r <= idle_cnt_r + TW'(1);
        end
    end
`else
    logic unused_timeout_s;
    // TIMEOUT only matters when the flush feature is built in.
    assign unused_timeout_s = (TIMEOUT > 0);
    assign timeout_hit_s    = 1'b0;
`endif

    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                          (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_s        = out_ready && !fifo_empty_s;

    // Byte write request: completed pair, or a timed-out lone low nibble.
    always_comb begin
        wr_req_s  = 1'b0;
        wr_byte_s = {BYTE_W{1'b0}};
        if (enable && frame_ok_s && pending_r) begin
            wr_req_s  = 1'b1;
            wr_byte_s = {shreg_r, low_r};
        end else if (timeout_hit_s) begin
            wr_req_s  = 1'b1;
            wr_byte_s = {4'h0, low_r};
        end else begin
            wr_req_s  = 1'b0;
            wr_byte_s = {BYTE_W{1'b0}};
        end
    end

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push_s = wr_req_s && (!fifo_full_s || pop_s);
    assign drop_s = wr_req_s && fifo_full_s && !pop_s;

    // Data capture: one bit per strobe, placed by the bit counter, d0 first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_r   <= {NIBBLE_W{1'b0}};
            bit_cnt_r <= 2'd0;
        end else if (!enable) begin
            shreg_r   <= {NIBBLE_W{1'b0}};
            bit_cnt_r <= 2'd0;
        end else if (bit_strobe_s) begin
            shreg_r[bit_cnt_r] <= signal;
            bit_cnt_r          <= bit_cnt_r + 2'd1;
        end else if (!busy_s) begin
            bit_cnt_r <= 2'd0;
        end
    end

    // Nibble pairing: first good nibble is held, second completes the byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_r <= 1'b0;
            low_r     <= {NIBBLE_W{1'b0}};
        end else if (!enable) begin
            pending_r <= 1'b0;
            low_r     <= {NIBBLE_W{1'b0}};
        end else if (frame_ok_s) begin
            if (pending_r) begin
                pending_r <= 1'b0;
            end else begin
                low_r     <= shreg_r;
                pending_r <= 1'b1;
            end
        end else if (frame_err_s || frame_brk_s || timeout_hit_s) begin
            pending_r <= 1'b0;
        end
    end

    // Byte FIFO: circular buffer with an extra wrap bit on each pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {BYTE_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= wr_byte_s;
                wr_ptr_r                <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Statistics: saturating counters and the sticky overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_r  <= {CNT_W{1'b0}};
            brk_r  <= {CNT_W{1'b0}};
            drop_r <= {CNT_W{1'b0}};
            ovf_r  <= 1'b0;
        end else begin
            if (enable && frame_err_s) begin
                err_r <= sat_inc(err_r);
            end
            if (enable && frame_brk_s) begin
                brk_r <= sat_inc(brk_r);
            end
            if (drop_s) begin
                drop_r <= sat_inc(drop_r);
                ovf_r  <= 1'b1;
            end
        end
    end

    assign out_data   = mem_r[rd_ptr_r[AW-1:0]];
    assign out_valid  = !fifo_empty_s;
    assign err_count  = err_r;
    assign brk_count  = brk_r;
    assign drop_count = drop_r;
    assign overflow   = ovf_r;
    assign pending    = pending_r;
    assign busy       = busy_s;

endmodule

// File: tb/tb_uart_rx_byte_ctrl.sv
// Directed bench for uart_rx_byte_ctrl with hand-computed expected values.
module tb_uart_rx_byte_ctrl;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       signal = 1'b1;
    logic       enable = 1'b1;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic [7:0] err_count, brk_count, drop_count;
    logic       overflow, pending, busy;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_byte_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .signal     (signal),
        .enable     (enable),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_count  (err_count),
        .brk_count  (brk_count),
        .drop_count (drop_count),
        .overflow   (overflow),
        .pending    (pending),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        signal = b;
        tick();
    endtask

    task automatic send_frame(input logic [3:0] nib, input logic par_good, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(nib[i]);
        send_bit(par_good ? odd_parity(nib) : ~odd_parity(nib));
        send_bit(stop);
    endtask

    task automatic test_reset();
        tick(); tick();
        n_checks++; if ({out_valid, out_data} !== 9'h000) begin n_fail++; $display("FAIL reset_out: got %h required 000", {out_valid, out_data}); end
        n_checks++; if ({err_count, brk_count, drop_count} !== 24'h0) begin n_fail++; $display("FAIL reset_cnt: got %h required 0", {err_count, brk_count, drop_count}); end
        n_checks++; if ({overflow, pending, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b required 000", {overflow, pending, busy}); end
        reset_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send_frame(4'h5, 1'b1, 1'b1);
        send_frame(4'hA, 1'b1, 1'b1);
        n_checks++; if ({out_valid, pending} !== 2'b01) begin n_fail++; $display("FAIL b2b_at_stop: valid/pending got %b required 01", {out_valid, pending}); end
        signal = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin n_fail++; $display("FAIL b2b_data: got %b/%h required 1/a5", out_valid, out_data); end
        n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL b2b_pending: got %b required 0", pending); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse: valid got %b required 0", out_valid); end
        n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL b2b_err: got %0d required 0", err_count); end
    endtask

    task automatic test_parity_error();
        send_frame(4'h3, 1'b1, 1'b1);
        send_frame(4'h5, 1'b0, 1'b1);
        signal = 1'b1;
        tick();
        n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL par_err_count: got %0d required 1", err_count); end
        n_checks++; if ({pending, out_valid} !== 2'b00) begin n_fail++; $display("FAIL par_no_write: pending/valid got %b required 00", {pending, out_valid}); end
        send_frame(4'h1, 1'b1, 1'b1);
        send_frame(4'h2, 1'b1, 1'b1);
        signal = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h21) begin n_fail++; $display("FAIL par_next_pair: got %b/%h required 1/21", out_valid, out_data); end
        tick();
    endtask

    task automatic test_break();
        send_frame(4'h9, 1'b1, 1'b1);
        send_frame(4'h6, 1'b1, 1'b0);
        tick();
        n_checks++; if (brk_count !== 8'd1) begin n_fail++; $display("FAIL brk_count: got %0d required 1", brk_count); end
        n_checks++; if ({pending, out_valid} !== 2'b00) begin n_fail++; $display("FAIL brk_no_byte: pending/valid got %b required 00", {pending, out_valid}); end
        tick(); tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL brk_hold_low: busy got %b required 0", busy); end
        signal = 1'b1;
        tick();
        send_frame(4'h4, 1'b1, 1'b1);
        send_frame(4'h6, 1'b1, 1'b1);
        signal = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h64) begin n_fail++; $display("FAIL brk_recover: got %b/%h required 1/64", out_valid, out_data); end
        n_checks++; if (err_count !== 8'd1 || brk_count !== 8'd1) begin n_fail++; $display("FAIL brk_counts_stable: err %0d brk %0d required 1 1", err_count, brk_count); end
        tick();
    endtask

    task automatic test_overflow();
        logic [7:0] exp_b;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send_frame(4'(2 * k), 1'b1, 1'b1);
            send_frame(4'(2 * k + 1), 1'b1, 1'b1);
        end
        signal = 1'b1;
        tick();
        n_checks++; if (drop_count !== 8'd1 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_drop: drop %0d ovf %b required 1 1", drop_count, overflow); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_full_valid: got %b required 1", out_valid); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_b = {4'(2 * i + 1), 4'(2 * i)};
            n_checks++; if (out_valid !== 1'b1 || out_data !== exp_b) begin n_fail++; $display("FAIL ovf_drain_%0d: got %b/%h required 1/%h", i, out_valid, out_data, exp_b); end
            tick();
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drain_empty: valid got %b required 0", out_valid); end
    endtask

    task automatic test_full_pop();
        logic [7:0] fp_bytes [5];
        fp_bytes[0] = 8'hC1; fp_bytes[1] = 8'hD2; fp_bytes[2] = 8'hE3;
        fp_bytes[3] = 8'hF4; fp_bytes[4] = 8'h5A;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send_frame(fp_bytes[k][3:0], 1'b1, 1'b1);
            send_frame(fp_bytes[k][7:4], 1'b1, 1'b1);
        end
        out_ready = 1'b1;
        signal = 1'b1;
        tick();
        n_checks++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL fullpop_no_drop: drop %0d required 1", drop_count); end
        for (int i = 1; i < 5; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== fp_bytes[i]) begin n_fail++; $display("FAIL fullpop_drain_%0d: got %b/%h required 1/%h", i, out_valid, out_data, fp_bytes[i]); end
            tick();
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty: valid got %b required 0", out_valid); end
    endtask

    task automatic test_reset_midframe();
        out_ready = 1'b0;
        send_frame(4'hB, 1'b1, 1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        n_checks++; if ({pending, busy} !== 2'b11) begin n_fail++; $display("FAIL rst_pre: pending/busy got %b required 11", {pending, busy}); end
        reset_n = 1'b0;
        #1;
        n_checks++; if ({err_count, brk_count, drop_count} !== 24'h0 || overflow !== 1'b0) begin n_fail++; $display("FAIL rst_counters: got %h ovf %b required 0", {err_count, brk_count, drop_count}, overflow); end
        n_checks++; if ({pending, busy, out_valid} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b required 000", {pending, busy, out_valid}); end
        tick();
        reset_n = 1'b1;
        signal = 1'b1;
        tick(); tick();
        send_frame(4'hC, 1'b1, 1'b1);
        send_frame(4'hD, 1'b1, 1'b1);
        signal = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hDC) begin n_fail++; $display("FAIL rst_next_frame: got %b/%h required 1/dc", out_valid, out_data); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_enable_midframe();
        out_ready = 1'b1;
        send_frame(4'hE, 1'b1, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        enable = 1'b0;
        signal = 1'b0;
        tick();
        n_checks++; if ({busy, pending} !== 2'b00) begin n_fail++; $display("FAIL en_low_flags: busy/pending got %b required 00", {busy, pending}); end
        send_bit(1'b0);
        send_bit(1'b0);
        n_checks++; if ({err_count, brk_count, drop_count} !== 24'h0) begin n_fail++; $display("FAIL en_low_counters: got %h required 0", {err_count, brk_count, drop_count}); end
        enable = 1'b1;
        signal = 1'b1;
        tick(); tick();
        send_frame(4'h3, 1'b1, 1'b1);
        send_frame(4'hF, 1'b1, 1'b1);
        signal = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hF3) begin n_fail++; $display("FAIL en_next_frame: got %b/%h required 1/f3", out_valid, out_data); end
        n_checks++; if ({err_count, brk_count} !== 16'h0) begin n_fail++; $display("FAIL en_no_count: got %h required 0", {err_count, brk_count}); end
        tick();
    endtask

    task automatic test_timeout();
        out_ready = 1'b0;
        send_frame(4'h7, 1'b1, 1'b1);
        signal = 1'b1;
        repeat (40) tick();
`ifdef UART_RX_NIBBLE_TIMEOUT_EN
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h07) begin n_fail++; $display("FAIL timeout_flush: got %b/%h required 1/07", out_valid, out_data); end
        n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL timeout_pending: got %b required 0", pending); end
`else
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_none: valid got %b required 0", out_valid); end
        n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL timeout_held: pending got %b required 1", pending); end
`endif
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_parity_error();
        test_break();
        test_overflow();
        test_full_pop();
        test_reset_midframe();
        test_enable_midframe();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
